mem_cycle_sequencer: RTL
========================

// Module: mem_cycle_sequencer
// PURPOSE
//  Parametrised external-memory cycle sequencer; generates pad and strobe timing for the
//  processor's multiplexed address/data bus. Serves instruction fetch, load and store.
//  Sits between the control FSM (request/ack handshake) and the pad ring (MemEn/ENB, ALE, nME/nOE/nWE).
//  Adds over fixed fetch sequencing: write cycles, programmable phase lengths,
//  Ready-extended wait, multi-word bursts and a timeout/error path.
// PARAMETERS
//  ADDR_CYCLES  2   cycles ALE held high per word (>=1)
//  WAIT_STATES  2   minimum strobe cycles before Ready is sampled (>=0)
//  TURN_CYCLES  1   bus-idle cycles after each word (>=1)
//  BURST_MAX    4   maximum words per request (>=1)
//  TIMEOUT      15  DATA cycles without Ready before abort (>=1)
//  LEN_W        $clog2(BURST_MAX+1)  derived; do not override
// PORTS
//  Clock    in   1      system clock, rising edge
//  Reset    in   1      synchronous, active-high
//  Req      in   1      request; sampled only in IDLE
//  ReqWr    in   1      1 = write, 0 = read; captured with Req
//  ReqLen   in   LEN_W  words in burst; 0 treated as 1, >BURST_MAX clamped
//  Ready    in   1      memory ready, sampled in DATA
//  Busy     out  1      high in every non-IDLE state
//  Ack      out  1      word complete (read data valid on pads / write accepted)
//  AddrInc  out  1      advance external address counter; equals Ack
//  Done     out  1      one-cycle pulse on the last word's Ack or on abort
//  Err      out  1      one-cycle pulse on timeout abort
//  MemEn    out  1      pad output drive enable
//  ENB      out  1      pad input enable
//  ALE      out  1      address latch enable
//  nME      out  1      memory enable, active-low
//  nOE      out  1      output enable, active-low
//  nWE      out  1      write enable, active-low
// BEHAVIOUR
//  Reset: state IDLE, counters 0, MemEn=ENB=ALE=Busy=Ack=AddrInc=Done=Err=0,
//   nME=nOE=nWE=1. Reset is honoured mid-burst: next edge -> IDLE, no Ack/Done/Err.
//  States: IDLE -> ADDR -> WAIT -> DATA -> TURN -> (ADDR if words left | IDLE).
//   If WAIT_STATES=0, ADDR goes directly to DATA.
//  Strobes are Moore, decoded from the state register plus the captured ReqWr:
//   IDLE: all inactive.  ADDR: MemEn=1 ALE=1 nME=0.
//   WAIT/DATA read: ENB=1 nME=0 nOE=0.  WAIT/DATA write: MemEn=1 nME=0 nWE=0.
//   TURN: nME=1, all enables 0 (bus turnaround).
//  Ack = (state==DATA && Ready); this is the only Mealy output.
//   Done = Ack on last word. Err/Done are registered and pulse in TURN on timeout.
//  Req in IDLE at edge 0 -> ADDR cycles 1..ADDR_CYCLES, then WAIT for WAIT_STATES cycles,
//   then DATA until Ready. Defaults with Ready=1: Ack in cycle 5, TURN cycle 6, IDLE cycle 7.
//  Req while Busy is ignored; a new Req is accepted in the first IDLE cycle.
//  Burst: remaining-word count loaded from ReqLen and decremented on each Ack.
//   Every word re-runs ADDR (address re-latched).
//  Timeout: counts DATA cycles with Ready=0. Reaching TIMEOUT -> TURN, then IDLE
//   with Err=Done=1 in the TURN cycle. The rest of the burst is dropped.
//   Ready=1 in the same cycle the limit is reached: Ack wins and there is no Err.
//  ReqWr and ReqLen changing during Busy have no effect.
// STRUCTURE
//  Shared package bus_pkg: typedef enum mem_state_t {IDLE,ADDR,WAIT,DATA,TURN};
//   typedef struct packed strobe_t {MemEn,ENB,ALE,nME,nOE,nWE}; constant STROBE_IDLE.
//  One sub-module: phase_counter (loadable down-counter with zero flag).
//   Reused for the ADDR/WAIT/TURN lengths and the timeout count.
// TESTING
//  1 Read, len 1, Ready=1, defaults -> ALE cycles 1-2; nOE=0 ENB=1 cycles 3-5;
//    Ack+Done cycle 5; all inactive cycle 6; Busy=0 cycle 7.
//  2 Write, len 3, Ready=1 -> 3 Acks at cycles 5,11,17; nWE=0 only in WAIT/DATA;
//    nOE never low; Done only with third Ack.
//  3 Read with Ready low 4 DATA cycles -> DATA stretched to cycles 5-9; Ack cycle 9; no Err.
//  4 Ready never high, TIMEOUT=15 -> Err=Done=1 exactly once, no Ack; IDLE 2 cycles after expiry.
//    Ready high on the expiry cycle -> Ack, Err=0.
//  5 Reset asserted in DATA of word 2 of a len-4 burst -> reset strobe values next cycle;
//    no Done; new Req accepted normally afterwards.
//  6 ReqLen=0 and ReqLen=7 with BURST_MAX=4 -> 1 and 4 words respectively;
//    Req pulses during Busy ignored.

Source files
------------

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared types and helpers for the external-memory cycle sequencer.
//   mem_state_t   : sequencer phase (IDLE, ADDR, WAIT, DATA, TURN)
//   strobe_t      : pad/strobe bundle {MemEn, ENB, ALE, nME, nOE, nWE}
//   STROBE_IDLE   : every strobe inactive (also used for bus turnaround)
//   strobe_decode : Moore decode of phase + captured direction to strobes
//   max_int       : larger of two integers (used for counter sizing)
//   clamp_len     : burst length with 0 -> 1 and oversize -> maximum
// ---------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
    DATA = 3'd3,
    TURN = 3'd4
  } mem_state_t;

  typedef struct packed {
    logic MemEn;
    logic ENB;
    logic ALE;
    logic nME;
    logic nOE;
    logic nWE;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{MemEn: 1'b0, ENB: 1'b0, ALE: 1'b0,
                                      nME: 1'b1, nOE: 1'b1, nWE: 1'b1};

  // Reads drive the pad inputs and pull nOE; writes drive the pads and pull nWE.
  function automatic strobe_t strobe_decode(input mem_state_t st, input logic wr);
    strobe_t s;
    s = STROBE_IDLE;
    case (st)
      ADDR: begin
        s.MemEn = 1'b1;
        s.ALE   = 1'b1;
        s.nME   = 1'b0;
      end
      WAIT, DATA: begin
        if (wr) begin
          s.MemEn = 1'b1;
          s.nME   = 1'b0;
          s.nWE   = 1'b0;
        end else begin
          s.ENB   = 1'b1;
          s.nME   = 1'b0;
          s.nOE   = 1'b0;
        end
      end
      default: s = STROBE_IDLE;
    endcase
    return s;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clamp_len(input int len, input int max_len);
    int r;
    if (len == 0) begin
      r = 1;
    end else if (len > max_len) begin
      r = max_len;
    end else begin
      r = len;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_cycle_sequencer_phase_counter.sv
// ---------------------------------------------------------------------------
// phase_counter
// Loadable down-counter with a zero flag. Load has priority over decrement;
// decrement saturates at zero.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val this edge
//   load_val in   W-bit value to load
//   dec      in   decrement this edge (ignored while loading)
//   zero     out  count is zero
// ---------------------------------------------------------------------------
module phase_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count register: reset, load, or saturating decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/mem_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// mem_cycle_sequencer
// External-memory cycle sequencer for the multiplexed address/data bus.
// Each word runs ADDR (ALE) -> WAIT -> DATA (until Ready) -> TURN; bursts
// re-run ADDR per word. A DATA phase without Ready for TIMEOUT cycles aborts
// the request with an Err/Done pulse in the following TURN cycle.
// Ports:
//   Clock   in   rising-edge clock
//   Reset   in   synchronous active-high reset
//   Req     in   request, sampled only in IDLE
//   ReqWr   in   1 = write, 0 = read (captured with Req)
//   ReqLen  in   burst length (0 -> 1, > BURST_MAX -> BURST_MAX)
//   Ready   in   memory ready, sampled in DATA
//   Busy    out  not IDLE
//   Ack     out  word complete (DATA && Ready)
//   AddrInc out  advance external address counter (same as Ack)
//   Done    out  last word's Ack, or abort
//   Err     out  timeout abort
//   MemEn, ENB, ALE, nME, nOE, nWE  out  pad strobes
// ---------------------------------------------------------------------------
module mem_cycle_sequencer
  import bus_pkg::*;
#(
  parameter int ADDR_CYCLES = 2,
  parameter int WAIT_STATES = 2,
  parameter int TURN_CYCLES = 1,
  parameter int BURST_MAX   = 4,
  parameter int TIMEOUT     = 15,
  parameter int LEN_W       = $clog2(BURST_MAX + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req,
  input  logic             ReqWr,
  input  logic [LEN_W-1:0] ReqLen,
  input  logic             Ready,
  output logic             Busy,
  output logic             Ack,
  output logic             AddrInc,
  output logic             Done,
  output logic             Err,
  output logic             MemEn,
  output logic             ENB,
  output logic             ALE,
  output logic             nME,
  output logic             nOE,
  output logic             nWE
);

  // One counter width covers every phase length and the timeout.
  localparam int PH_MAX = max_int(max_int(ADDR_CYCLES, WAIT_STATES),
                                  max_int(TURN_CYCLES, TIMEOUT));
  localparam int CNT_W  = $clog2(PH_MAX + 1);

  // Counters are loaded with length-1 so the zero flag marks a phase's last cycle.
  localparam logic [CNT_W-1:0] ADDR_LOAD = CNT_W'(ADDR_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT - 1);

  mem_state_t       state_r;
  mem_state_t       state_nxt_s;
  logic             wr_r;
  logic             wr_nxt_s;
  logic [LEN_W-1:0] words_r;
  logic [LEN_W-1:0] words_nxt_s;
  logic             err_r;
  logic             busy_r;
  strobe_t          strobe_r;
  logic             timeout_s;
  logic             ack_s;

  logic             ph_load_s;
  logic [CNT_W-1:0] ph_val_s;
  logic             ph_dec_s;
  logic             ph_zero_s;
  logic             to_load_s;
  logic             to_dec_s;
  logic             to_zero_s;

  // Shared ADDR/WAIT/TURN phase-length counter.
  phase_counter #(.W(CNT_W)) u_phase (
    .clk      (Clock),
    .rst      (Reset),
    .load     (ph_load_s),
    .load_val (ph_val_s),
    .dec      (ph_dec_s),
    .zero     (ph_zero_s)
  );

  // DATA-phase timeout counter (counts Ready-low DATA cycles).
  phase_counter #(.W(CNT_W)) u_timeout (
    .clk      (Clock),
    .rst      (Reset),
    .load     (to_load_s),
    .load_val (TO_LOAD),
    .dec      (to_dec_s),
    .zero     (to_zero_s)
  );

  // Next-state, capture and counter-control decode.
  always_comb begin
    state_nxt_s = state_r;
    wr_nxt_s    = wr_r;
    words_nxt_s = words_r;
    timeout_s   = 1'b0;
    ph_load_s   = 1'b0;
    ph_val_s    = ADDR_LOAD;
    ph_dec_s    = 1'b0;
    to_load_s   = 1'b0;
    to_dec_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (Req) begin
          state_nxt_s = ADDR;
          wr_nxt_s    = ReqWr;
          words_nxt_s = LEN_W'(clamp_len(int'(ReqLen), BURST_MAX));
          ph_load_s   = 1'b1;
          ph_val_s    = ADDR_LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADDR: begin
        if (!ph_zero_s) begin
          ph_dec_s = 1'b1;
        end else if (WAIT_STATES == 0) begin
          state_nxt_s = DATA;
          to_load_s   = 1'b1;
        end else begin
          state_nxt_s = WAIT;
          ph_load_s   = 1'b1;
          ph_val_s    = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (ph_zero_s) begin
          state_nxt_s = DATA;
          to_load_s   = 1'b1;
        end else begin
          ph_dec_s = 1'b1;
        end
      end
      DATA: begin
        // Ready on the expiry cycle completes the word rather than aborting.
        if (Ready) begin
          state_nxt_s = TURN;
          words_nxt_s = words_r - LEN_W'(1);
          ph_load_s   = 1'b1;
          ph_val_s    = TURN_LOAD;
        end else if (to_zero_s) begin
          state_nxt_s = TURN;
          words_nxt_s = '0;
          timeout_s   = 1'b1;
          ph_load_s   = 1'b1;
          ph_val_s    = TURN_LOAD;
        end else begin
          to_dec_s = 1'b1;
        end
      end
      TURN: begin
        if (!ph_zero_s) begin
          ph_dec_s = 1'b1;
        end else if (words_r != '0) begin
          state_nxt_s = ADDR;
          ph_load_s   = 1'b1;
          ph_val_s    = ADDR_LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Sequencer state plus registered Moore outputs, decoded from the next state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r  <= IDLE;
      wr_r     <= 1'b0;
      words_r  <= '0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      strobe_r <= STROBE_IDLE;
    end else begin
      state_r  <= state_nxt_s;
      wr_r     <= wr_nxt_s;
      words_r  <= words_nxt_s;
      err_r    <= timeout_s;
      busy_r   <= (state_nxt_s != IDLE);
      strobe_r <= strobe_decode(state_nxt_s, wr_nxt_s);
    end
  end

  // Ack is the only combinational output; suppressed while reset is applied.
  assign ack_s   = (state_r == DATA) && Ready && !Reset;
  assign Ack     = ack_s;
  assign AddrInc = ack_s;
  assign Done    = (ack_s && (words_r == LEN_W'(1))) || err_r;
  assign Err     = err_r;
  assign Busy    = busy_r;
  assign MemEn   = strobe_r.MemEn;
  assign ENB     = strobe_r.ENB;
  assign ALE     = strobe_r.ALE;
  assign nME     = strobe_r.nME;
  assign nOE     = strobe_r.nOE;
  assign nWE     = strobe_r.nWE;

endmodule
